// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO frame reader.
package fifo_rd_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned LEN_W      = 8;

    typedef enum logic [0:0] {
        S_HDR,
        S_PAY
    } state_e;

endpackage

// File: rtl/fifo_frame_reader_if.sv
// FIFO read port plus outgoing byte stream of the frame reader.
interface fifo_frame_reader_if
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_rd_en;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_last;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data,
        output m_last
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data,
        input  m_last
    );

endinterface

// File: rtl/fifo_rd_skid.sv
// Circular {last,data} output buffer; head entry drives the stream directly.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned BUF_DEPTH = 2,
    localparam int unsigned PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
    localparam int unsigned BCNT_W   = $clog2(BUF_DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              wr_last_i,
    output logic [BCNT_W-1:0] count_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_last_o
);

    logic [DATA_W:0]   mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [BCNT_W-1:0] count_q, count_d;
    logic              do_wr, do_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_rd = (count_q != '0) && m_ready_i;
    // A full buffer still accepts a write when the head leaves in the same cycle.
    assign do_wr = wr_en_i && ((count_q != BCNT_W'(BUF_DEPTH)) || do_rd);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + BCNT_W'(1);
            2'b01:   count_d = count_q - BCNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= {wr_last_i, wr_data_i};
    end

    assign count_o               = count_q;
    assign m_valid_o             = (count_q != '0);
    assign {m_last_o, m_data_o}  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_frame_reader.sv
// Pops bytes from the async FIFO read port and forwards payload of length-prefixed frames.
module fifo_frame_reader
    import fifo_rd_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned BUF_DEPTH  = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                rd_clk,
    input  logic                rd_rst,
    fifo_frame_reader_if.master bus,
    output logic [CNT_W-1:0]    frame_cnt,
    output logic                err_zero_len
);

    localparam int unsigned BCNT_W = $clog2(BUF_DEPTH + 1);

    logic [BCNT_W-1:0] buf_count;
    logic [BCNT_W:0]   credit_used;
    logic              inflight;
    logic              pop;
    logic              ret_valid;
    logic [DATA_W-1:0] ret_data;
    logic [LEN_W-1:0]  hdr_len;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  remaining_q, remaining_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic              buf_wr, buf_last;
    logic              skid_valid, skid_last;
    logic [DATA_W-1:0] skid_data;

    // Credit counts every pop, headers included, so returned bytes always find room.
    assign credit_used    = {1'b0, buf_count} + {{BCNT_W{1'b0}}, inflight};
    assign pop            = !rd_rst && !bus.fifo_empty && (credit_used < (BCNT_W + 1)'(BUF_DEPTH));
    assign bus.fifo_rd_en = pop;
    assign ret_data       = bus.fifo_rd_data;
    assign hdr_len        = ret_data[LEN_W-1:0];

    // RD_LATENCY is 0 or 1: at most one pop is ever outstanding.
    if (RD_LATENCY == 0) begin : g_lat0
        assign ret_valid = pop;
        assign inflight  = 1'b0;
    end else begin : g_lat1
        logic ret_valid_q;
        always_ff @(posedge rd_clk) begin
            if (rd_rst) ret_valid_q <= 1'b0;
            else        ret_valid_q <= pop;
        end
        assign ret_valid = ret_valid_q;
        assign inflight  = ret_valid_q;
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        err_d       = 1'b0;
        buf_wr      = 1'b0;
        buf_last    = 1'b0;
        if (ret_valid) begin
            unique case (state_q)
                S_HDR: begin
                    if (hdr_len == '0) begin
                        err_d = 1'b1;
                    end else begin
                        remaining_d = hdr_len;
                        state_d     = S_PAY;
                    end
                end
                S_PAY: begin
                    buf_wr      = 1'b1;
                    buf_last    = (remaining_q == LEN_W'(1));
                    remaining_d = remaining_q - LEN_W'(1);
                    if (buf_last) state_d = S_HDR;
                end
                default: state_d = S_HDR;
            endcase
        end
    end

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (skid_valid && bus.m_ready && skid_last) frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q     <= S_HDR;
            remaining_q <= '0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    fifo_rd_skid #(
        .DATA_W    (DATA_W),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_skid (
        .clk_i     (rd_clk),
        .rst_i     (rd_rst),
        .wr_en_i   (buf_wr),
        .wr_data_i (ret_data),
        .wr_last_i (buf_last),
        .count_o   (buf_count),
        .m_valid_o (skid_valid),
        .m_ready_i (bus.m_ready),
        .m_data_o  (skid_data),
        .m_last_o  (skid_last)
    );

    assign bus.m_valid  = skid_valid;
    assign bus.m_data   = skid_data;
    assign bus.m_last   = skid_last;
    assign frame_cnt    = frame_cnt_q;
    assign err_zero_len = err_q;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Drives two reader instances (RD_LATENCY 0 and 1) from one FIFO byte stream and scoreboards both.
module tb_fifo_frame_reader;

    localparam int unsigned DEPTH0 = 2;
    localparam int unsigned DEPTH1 = 3;
    localparam int unsigned CNTW0  = 16;
    localparam int unsigned CNTW1  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_frame_reader_if #(.DATA_W(8)) if0 ();
    fifo_frame_reader_if #(.DATA_W(8)) if1 ();

    logic [CNTW0-1:0] fcnt0;
    logic [CNTW1-1:0] fcnt1;
    logic             err0, err1;

    fifo_frame_reader #(
        .DATA_W(8), .RD_LATENCY(0), .BUF_DEPTH(DEPTH0), .CNT_W(CNTW0)
    ) u_dut0 (
        .rd_clk(clk), .rd_rst(rst), .bus(if0), .frame_cnt(fcnt0), .err_zero_len(err0)
    );

    fifo_frame_reader #(
        .DATA_W(8), .RD_LATENCY(1), .BUF_DEPTH(DEPTH1), .CNT_W(CNTW1)
    ) u_dut1 (
        .rd_clk(clk), .rd_rst(rst), .bus(if1), .frame_cnt(fcnt1), .err_zero_len(err1)
    );

    // FIFO model: bytes queued by stimulus appear at the next rising edge.
    bit   [7:0] pq[$];
    bit   [7:0] fq0[$];
    bit   [7:0] fq1[$];
    logic       emp0 = 1'b1, emp1 = 1'b1;
    logic [7:0] rdd0 = '0, rdd1 = '0;
    logic       m_ready = 1'b0;

    assign if0.fifo_empty   = emp0;
    assign if1.fifo_empty   = emp1;
    assign if0.fifo_rd_data = rdd0;
    assign if1.fifo_rd_data = rdd1;
    assign if0.m_ready      = m_ready;
    assign if1.m_ready      = m_ready;

    always @(posedge clk) begin
        bit [7:0] b;
        if (if0.fifo_rd_en && fq0.size() > 0) b = fq0.pop_front();
        if (if1.fifo_rd_en && fq1.size() > 0) rdd1 <= fq1.pop_front();
        while (pq.size() > 0) begin
            b = pq.pop_front();
            fq0.push_back(b);
            fq1.push_back(b);
        end
        emp0 <= (fq0.size() == 0);
        emp1 <= (fq1.size() == 0);
        if (fq0.size() > 0) rdd0 <= fq0[0];
    end

    int   ready_mode = 0;
    logic ready_lvl  = 1'b1;
    always @(negedge clk) begin
        case (ready_mode)
            0:       m_ready = ready_lvl;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = ~m_ready;
        endcase
    end

    logic [1:0]      vld, lst, ern, rde, emp;
    logic [1:0][7:0] dat;
    assign vld = {if1.m_valid, if0.m_valid};
    assign lst = {if1.m_last, if0.m_last};
    assign dat = {if1.m_data, if0.m_data};
    assign ern = {err1, err0};
    assign rde = {if1.fifo_rd_en, if0.fifo_rd_en};
    assign emp = {emp1, emp0};

    int       checks = 0;
    int       errors = 0;
    bit [8:0] exp0[$];
    bit [8:0] exp1[$];
    int       frames_exp = 0;
    int       err_exp = 0;
    int       err_seen [2];
    int       pops [2];
    bit       hold [2];
    bit [8:0] hold_val [2];
    bit [7:0] frm[$];

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on each accepted byte, checks hold-stability.
    always begin
        bit [8:0] e;
        bit       got;
        @(negedge clk);
        #1;
        for (int l = 0; l < 2; l++) begin
            if (rst) begin
                hold[l] = 1'b0;
            end else begin
                if (rde[l]) begin
                    pops[l]++;
                    chk($sformatf("pop_while_empty lane%0d", l), int'(emp[l]), 0);
                end
                if (ern[l]) err_seen[l]++;
                if (hold[l]) begin
                    chk($sformatf("hold_stable lane%0d", l), int'({vld[l], lst[l], dat[l]}),
                        int'({1'b1, hold_val[l]}));
                end
                hold[l] = 1'b0;
                if (vld[l]) begin
                    if (m_ready) begin
                        got = 1'b0;
                        if (l == 0 && exp0.size() > 0) begin e = exp0.pop_front(); got = 1'b1; end
                        if (l == 1 && exp1.size() > 0) begin e = exp1.pop_front(); got = 1'b1; end
                        checks++;
                        if (!got) begin
                            errors++;
                            $display("FAIL unexpected_output lane%0d: got %03h, required none",
                                     l, {lst[l], dat[l]});
                        end else if ({lst[l], dat[l]} != e) begin
                            errors++;
                            $display("FAIL output lane%0d: got {last,data}=%03h, required %03h",
                                     l, {lst[l], dat[l]}, e);
                        end
                    end else begin
                        hold[l]     = 1'b1;
                        hold_val[l] = {lst[l], dat[l]};
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_exp(input bit last, input bit [7:0] b);
        exp0.push_back({last, b});
        exp1.push_back({last, b});
    endtask

    // Reference model: header first, payload flagged last on its final byte.
    task automatic send_frame(input int gap_pct);
        int n;
        n = frm.size();
        pq.push_back(8'(n));
        if (n == 0) err_exp++;
        else        frames_exp++;
        for (int i = 0; i < n; i++) begin
            pq.push_back(frm[i]);
            push_exp(i == n - 1, frm[i]);
            if ($urandom_range(0, 99) < gap_pct) tick($urandom_range(1, 3));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        #1;
        chk("reset m_valid lane0", int'(vld[0]), 0);
        chk("reset m_valid lane1", int'(vld[1]), 0);
        chk("reset fifo_rd_en lane0", int'(rde[0]), 0);
        chk("reset fifo_rd_en lane1", int'(rde[1]), 0);
        chk("reset frame_cnt lane0", int'(fcnt0), 0);
        chk("reset frame_cnt lane1", int'(fcnt1), 0);
        chk("reset err_zero_len lane0", int'(err0), 0);
        chk("reset err_zero_len lane1", int'(err1), 0);
        @(negedge clk);
        rst = 1'b0;
        frames_exp = 0;
    endtask

    task automatic wait_drain(input string name, input bit keep_ready);
        int k;
        k = 0;
        if (!keep_ready) begin
            ready_mode = 0;
            ready_lvl  = 1'b1;
        end
        while ((pq.size() + fq0.size() + fq1.size() + exp0.size() + exp1.size() != 0 ||
                vld != 2'b00) && k < 5000) begin
            tick(1);
            k++;
        end
        tick(3);
        checks++;
        if (k >= 5000) begin
            errors++;
            $display("FAIL %s drain: got %0d/%0d bytes outstanding, required 0", name,
                     exp0.size(), exp1.size());
        end
    endtask

    task automatic end_check(input string name);
        chk({name, " frame_cnt lane0"}, int'(fcnt0), frames_exp % 65536);
        chk({name, " frame_cnt lane1"}, int'(fcnt1), frames_exp % 16);
        chk({name, " err_zero_len pulses lane0"}, err_seen[0], err_exp);
        chk({name, " err_zero_len pulses lane1"}, err_seen[1], err_exp);
    endtask

    initial begin
        int p0, p1;
        do_reset();

        frm = {8'hAA, 8'hBB, 8'hCC};
        send_frame(0);
        wait_drain("t1", 1'b0);
        end_check("t1");

        do_reset();
        frm = {8'h11};
        send_frame(0);
        frm = {8'h22, 8'h33};
        send_frame(0);
        wait_drain("t2", 1'b0);
        end_check("t2");

        do_reset();
        frm.delete();
        send_frame(0);
        frm = {8'h5A};
        send_frame(0);
        wait_drain("t3", 1'b0);
        end_check("t3");

        do_reset();
        frm.delete();
        for (int i = 0; i < 255; i++) frm.push_back(8'(i));
        ready_mode = 2;
        send_frame(0);
        wait_drain("t4", 1'b1);
        end_check("t4");

        do_reset();
        ready_mode = 0;
        ready_lvl  = 1'b1;
        pq.push_back(8'd5);
        tick(4);
        ready_lvl = 1'b0;
        tick(2);
        p0 = pops[0];
        p1 = pops[1];
        for (int i = 0; i < 5; i++) begin
            pq.push_back(8'(8'h40 + i));
            push_exp(i == 4, 8'(8'h40 + i));
        end
        frames_exp++;
        tick(20);
        chk("t5 pops while stalled lane0", pops[0] - p0, DEPTH0);
        chk("t5 pops while stalled lane1", pops[1] - p1, DEPTH1);
        chk("t5 fifo_rd_en low lane0", int'(rde[0]), 0);
        chk("t5 fifo_rd_en low lane1", int'(rde[1]), 0);
        chk("t5 m_valid held lane0", int'(vld[0]), 1);
        chk("t5 m_valid held lane1", int'(vld[1]), 1);
        wait_drain("t5", 1'b0);
        end_check("t5");

        do_reset();
        pq.push_back(8'd4);
        pq.push_back(8'hA0);
        pq.push_back(8'hA1);
        push_exp(1'b0, 8'hA0);
        push_exp(1'b0, 8'hA1);
        wait_drain("t6 partial", 1'b0);
        end_check("t6 partial");
        pq.push_back(8'd1);
        pq.push_back(8'h99);
        do_reset();
        push_exp(1'b1, 8'h99);
        frames_exp = 1;
        wait_drain("t6", 1'b0);
        end_check("t6");

        do_reset();
        ready_mode = 1;
        for (int f = 0; f < 60; f++) begin
            frm.delete();
            if ($urandom_range(0, 9) != 0) begin
                for (int i = 0; i < int'($urandom_range(1, 16)); i++) frm.push_back(8'($urandom));
            end
            send_frame(30);
            tick($urandom_range(0, 3));
        end
        wait_drain("random", 1'b1);
        end_check("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
